// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen -- upstream command stage for an SR flip-flop.
//
// Raw asynchronous set/clear requests are synchronized (2 flops), debounced,
// edge-detected and turned into clean one-cycle s/r pulses. s and r can never
// be high together. After every pulse a hold-off window discards new events.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   set_req      raw asynchronous set request (active high)
//   clr_req      raw asynchronous clear request (active high)
//   s, r         registered one-cycle set / reset pulses
//   busy         high in SET_PULSE, CLR_PULSE and HOLDOFF (registered)
//   conflict     set and clear events coincided in IDLE (one cycle)
//   dropped      an event arrived while busy and was discarded (one cycle)
//   conflict_cnt saturating count of conflict/dropped pulses
//                (only when SR_CMD_CONFLICT_CNT_EN is defined)
//
// Optional feature macro: SR_CMD_CONFLICT_CNT_EN

// Per-channel synchronizer + debouncer + rising-edge detector.
module sr_cmd_db #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ev
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic          db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], req};
      db_q <= db;
      // cnt holds the number of disagreeing samples already seen; the
      // DEBOUNCE_CYCLES-th consecutive one flips the level.
      if (sync[1] != db) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db  <= ~db;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign ev = db & ~db_q;
endmodule

module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int SET_PRIORITY    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic       dropped
`ifdef SR_CMD_CONFLICT_CNT_EN
  ,output logic [7:0] conflict_cnt
`endif
);
  localparam int NUM_CH = 2;  // ch0 = set, ch1 = clear
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SET_PULSE, CLR_PULSE, HOLDOFF} state_t;

  logic [NUM_CH-1:0] req, ev;
  logic              ev_s, ev_r;
  state_t            state, state_nxt;
  logic [HW-1:0]     hcnt, hcnt_nxt;

  assign req = {clr_req, set_req};

  sr_cmd_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_CH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ev    (ev)
  );

  assign ev_s = ev[0];
  assign ev_r = ev[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      s     <= 1'b0;
      r     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      // Outputs registered from the next state so they are clean flop outputs.
      s     <= (state_nxt == SET_PULSE);
      r     <= (state_nxt == CLR_PULSE);
      busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    conflict  = 1'b0;
    dropped   = 1'b0;
    case (state)
      IDLE: begin
        if (ev_s && ev_r) begin
          conflict  = 1'b1;
          state_nxt = (SET_PRIORITY != 0) ? SET_PULSE : CLR_PULSE;
        end else if (ev_s) begin
          state_nxt = SET_PULSE;
        end else if (ev_r) begin
          state_nxt = CLR_PULSE;
        end
      end
      SET_PULSE, CLR_PULSE: begin
        dropped   = ev_s | ev_r;
        hcnt_nxt  = '0;
        state_nxt = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
      end
      HOLDOFF: begin
        dropped = ev_s | ev_r;
        if (hcnt == HW'(HOLDOFF_CYCLES - 1)) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SR_CMD_CONFLICT_CNT_EN
  // conflict only occurs in IDLE and dropped only while busy, so at most one
  // of them is high in a cycle: a single +1 covers both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= 8'd0;
    else if ((conflict || dropped) && conflict_cnt != 8'hFF)
      conflict_cnt <= conflict_cnt + 8'd1;
  end
`else
  // No event counter in this build.
`endif
endmodule

// File: tb/tb_sr_cmd_gen.sv
module tb_sr_cmd_gen;
  localparam int D = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic [1:0] s, r, busy, conflict, dropped;
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [1:0][7:0] ccnt;
`endif

  always #5 clk = ~clk;

  // Two DUTs sharing stimulus: k=0 clear wins conflicts, k=1 set wins.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .SET_PRIORITY(k)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .s        (s[k]),
      .r        (r[k]),
      .busy     (busy[k]),
      .conflict (conflict[k]),
      .dropped  (dropped[k])
`ifdef SR_CMD_CONFLICT_CNT_EN
      ,.conflict_cnt (ccnt[k])
`endif
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Expected pulse record: {s, r, conflict, dropped} plus the cycle it shows up.
  typedef struct {
    logic [3:0] bits;
    int         stamp;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // ---------------- reference model ----------------
  // Debounce state is shared (same inputs); command state is per DUT and is
  // kept as "cycles of busyness left" rather than as an FSM.
  bit [1:0] m_s1, m_s2, m_lvl, m_lvlq;
  int       m_run [2];
  int       m_left [2];
  bit       m_kind_s [2];
  bit       m_pend [2];
  int       m_cnt [2];
  bit       exp_busy [2];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlq = '0;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_left[k] = 0; m_kind_s[k] = 0;
      m_pend[k] = 0; m_cnt[k] = 0; exp_busy[k] = 0;
    end
    while (q0.size() > 0 && q0[$].stamp >= cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].stamp >= cyc) void'(q1.pop_back());
  endtask

  task automatic model_step();
    bit [1:0] ev_old, ev_new;
    exp_t e;
    bit sb, rb, cf, dr;
    ev_old = m_lvl & ~m_lvlq;
    for (int k = 0; k < 2; k++) begin
      if (m_pend[k] && m_cnt[k] < 255) m_cnt[k]++;
      if (m_left[k] > 0) m_left[k]--;
      else if (ev_old != 2'b00) begin
        m_left[k]   = 1 + H;
        m_kind_s[k] = (ev_old == 2'b11) ? (k == 1) : ev_old[0];
      end
    end
    m_lvlq = m_lvl;
    for (int c = 0; c < 2; c++) begin
      if (m_s2[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
        end
      end else m_run[c] = 0;
    end
    m_s2 = m_s1;
    m_s1 = {clr_req, set_req};
    ev_new = m_lvl & ~m_lvlq;
    for (int k = 0; k < 2; k++) begin
      sb = (m_left[k] == H + 1) && m_kind_s[k];
      rb = (m_left[k] == H + 1) && !m_kind_s[k];
      cf = (m_left[k] == 0) && (ev_new == 2'b11);
      dr = (m_left[k] > 0) && (ev_new != 2'b00);
      exp_busy[k] = (m_left[k] > 0);
      m_pend[k] = cf | dr;
      e.bits  = {sb, rb, cf, dr};
      e.stamp = cyc;
      if (e.bits != 4'b0) begin
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic [3:0] bits;
    bit empty;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("s_and_r", int'(s[k] & r[k]), 0);
        chk("busy", int'(busy[k]), int'(exp_busy[k]));
`ifdef SR_CMD_CONFLICT_CNT_EN
        chk("conflict_cnt", int'(ccnt[k]), m_cnt[k]);
`endif
        bits = {s[k], r[k], conflict[k], dropped[k]};
        if (bits != 4'b0) begin
          empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse dut=%0d actual=%b required=none cyc=%0d", k, bits, cyc);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("pulse_bits", int'(bits), int'(e.bits));
            chk("pulse_cycle", cyc, e.stamp);
          end
        end
      end
    end
  end

  always @(negedge clk)
    assert (!(s[0] && r[0]) && !(s[1] && r[1])) else $error("FAIL s_r_overlap");

  // ---------------- stimulus ----------------
  task automatic stp(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_s0(output int lat, input int t0);
    int w = 0;
    while (!s[0] && w < 30) begin
      stp(1);
      w++;
    end
    lat = cyc - t0;
  endtask

  initial begin
    int t0, lat, b;
    stp(2);
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_conflict", int'(conflict), 0);
    stp(1);
    rst_n = 1'b1;
    stp(3);

    // set request held high: latency and busy length
    t0 = cyc;
    set_req = 1'b1;
    wait_s0(lat, t0);
    chk("set_latency", lat, D + 3);
    b = 0;
    while (busy[0] && b < 20) begin
      b++;
      stp(1);
    end
    chk("busy_length", b, 1 + H);
    set_req = 1'b0;
    stp(12);

    // short glitch on clr_req
    clr_req = 1'b1;
    stp(D - 1);
    clr_req = 1'b0;
    stp(12);

    // simultaneous set and clear
    set_req = 1'b1; clr_req = 1'b1;
    stp(12);
    set_req = 1'b0; clr_req = 1'b0;
    stp(12);

    // clear event landing in hold-off
    set_req = 1'b1;
    stp(2);
    clr_req = 1'b1;
    stp(12);
    set_req = 1'b0; clr_req = 1'b0;
    stp(12);

    // reset during the set pulse, then full latency again
    set_req = 1'b1;
    t0 = cyc;
    wait_s0(lat, t0);
    chk("pre_reset_latency", lat, D + 3);
    rst_n = 1'b0;
    #1;
    chk("reset_abort_s", int'(s[0]), 0);
    chk("reset_abort_busy", int'(busy[0]), 0);
    stp(2);
    t0 = cyc;
    rst_n = 1'b1;
    wait_s0(lat, t0);
    chk("post_reset_latency", lat, D + 3);
    set_req = 1'b0;
    stp(12);

    // random traffic
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) set_req = ~set_req;
      if ($urandom_range(0, 3) == 0) clr_req = ~clr_req;
      stp(1);
    end
    set_req = 1'b0; clr_req = 1'b0;
    stp(12);

    // many conflicts
    repeat (300) begin
      set_req = 1'b1; clr_req = 1'b1;
      stp(10);
      set_req = 1'b0; clr_req = 1'b0;
      stp(8);
    end
    stp(10);
`ifdef SR_CMD_CONFLICT_CNT_EN
    chk("conflict_cnt_sat0", int'(ccnt[0]), 255);
    chk("conflict_cnt_sat1", int'(ccnt[1]), 255);
`endif
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
